andtest_seq_ctrl: RTL and testbench

Self-test sequencer for the AND-gate LED test datapath. Walks the gate inputs `a`/`b` through all four truth-table combinations with a programmable settle and dwell time, samples the gate output `y` fed back on `y_in`, counts mismatches and reports pass/fail. It sits between the clock/reset buffers and the gate under test, replacing free-running stimulus with a start/done controlled run, and owns the tristate status-LED drive.

---
 rtl/andtest_pkg.sv | 19 +
 rtl/andtest_dwell_timer.sv | 30 +++
 rtl/andtest_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_andtest_seq_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/andtest_pkg.sv
// Shared types and constants for the AND-gate LED self-test sequencer.
package andtest_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] STEP_LAST = 2'd3;
  localparam logic [2:0] ERR_MAX   = 3'd7;

  // Larger of two cycle counts, used to size the shared phase timer.
  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/andtest_dwell_timer.sv
// Loadable down-counter with a terminal-count flag; times both the settle
// and the dwell phase of each truth-table step.
module andtest_dwell_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // Reload on request, otherwise count down to zero while enabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A phase of N cycles is loaded with N-1, so zero marks its last cycle.
  assign tc = en && (cnt == '0);

endmodule

// File: rtl/andtest_seq_ctrl.sv
// Self-test sequencer: steps the AND gate through 00,01,10,11, samples the
// fed-back output after a settle time, counts mismatches and drives the
// status LED once a single-pass run completes.
module andtest_seq_ctrl
  import andtest_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int DWELL_CYCLES  = 3,
  parameter int LOOP          = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       y_in,
  output logic       a,
  output logic       b,
  output logic [1:0] step,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       led_oe,
  output logic       led_o
);

  localparam int CNT_W = $clog2(max_int(SETTLE_CYCLES, DWELL_CYCLES) + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);

  state_t           state;
  logic             tc;
  logic             tmr_load;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_val;
  logic             accept_start;

  assign accept_start = start && ((state == ST_IDLE) || (state == ST_DONE));

  // Timer reload: settle length on run start and on each new step,
  // dwell length when the sample has been taken.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = SETTLE_LOAD;
    tmr_en   = (state == ST_SETTLE) || (state == ST_DWELL);
    if (accept_start) begin
      tmr_load = 1'b1;
    end else if ((state == ST_SETTLE) && tc) begin
      tmr_load = 1'b1;
      tmr_val  = DWELL_LOAD;
    end else if ((state == ST_DWELL) && tc) begin
      tmr_load = 1'b1;
    end
  end

  andtest_dwell_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .tc       (tc)
  );

  // Sequencer FSM with mismatch scoreboard and LED status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      a         <= 1'b0;
      b         <= 1'b0;
      step      <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      led_oe    <= 1'b0;
      led_o     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            step      <= 2'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            err_count <= 3'd0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            led_oe    <= 1'b0;
            state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tc) begin
            // y_in is only trusted on the last settle cycle.
            if ((y_in != (a & b)) && (err_count != ERR_MAX)) begin
              err_count <= err_count + 3'd1;
            end
            state <= ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (tc) begin
            if (step != STEP_LAST) begin
              step   <= step + 2'd1;
              {a, b} <= step + 2'd1;
              state  <= ST_SETTLE;
            end else if (LOOP != 0) begin
              step   <= 2'd0;
              {a, b} <= 2'd0;
              state  <= ST_SETTLE;
            end else begin
              busy   <= 1'b0;
              done   <= 1'b1;
              pass   <= (err_count == 3'd0);
              led_oe <= 1'b1;
              led_o  <= (err_count == 3'd0);
              state  <= ST_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_andtest_seq_ctrl.sv
// Directed self-checking bench for andtest_seq_ctrl: single-pass DUT with a
// modelled gate (healthy / stuck-at-0 / inverted) and a LOOP=1 DUT fed a
// stuck-at-1 output.
module tb_andtest_seq_ctrl;

  localparam int S  = 2;
  localparam int D  = 3;
  localparam int SD = S + D;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       y_in;
  logic       a, b, busy, done, pass, led_oe, led_o;
  logic [1:0] step;
  logic [2:0] err_count;

  logic       start2;
  logic       a2, b2, busy2, done2, pass2, led_oe2, led_o2;
  logic [1:0] step2;
  logic [2:0] err_count2;

  int gate_mode;   // 0 healthy, 1 stuck-at-0, 2 inverted
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [2:0] err;
  } ev_t;

  logic [1:0] exp_ab_q[$];
  ev_t        loop_q[$];

  always #5 clk = ~clk;

  // Gate under test as seen by the sequencer.
  assign y_in = (gate_mode == 0) ? (a & b) :
                (gate_mode == 1) ? 1'b0 : ~(a & b);

  andtest_seq_ctrl #(.SETTLE_CYCLES(S), .DWELL_CYCLES(D), .LOOP(0)) dut (
    .clk(clk), .reset(reset), .start(start), .y_in(y_in),
    .a(a), .b(b), .step(step), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .led_oe(led_oe), .led_o(led_o)
  );

  andtest_seq_ctrl #(.SETTLE_CYCLES(S), .DWELL_CYCLES(D), .LOOP(1)) dut_loop (
    .clk(clk), .reset(reset), .start(start2), .y_in(1'b1),
    .a(a2), .b(b2), .step(step2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .led_oe(led_oe2), .led_o(led_o2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ab"},     32'({a, b}), 32'd0);
    check({tag, "_step"},   32'(step), 32'd0);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_done"},   32'(done), 32'd0);
    check({tag, "_pass"},   32'(pass), 32'd0);
    check({tag, "_err"},    32'(err_count), 32'd0);
    check({tag, "_led_oe"}, 32'(led_oe), 32'd0);
    check({tag, "_led_o"},  32'(led_o), 32'd0);
  endtask

  // One single-pass run; poke_cyc >= 0 raises start so it is sampled at
  // edge E0+poke_cyc+1 while the run is busy.
  task automatic run_single(input string tag, input int mode, input int exp_err,
                            input int poke_cyc);
    logic [1:0] exp_ab;
    int         done_cnt;
    logic       exp_pass;
    gate_mode = mode;
    exp_pass  = (exp_err == 0);
    for (int k = 0; k < 4; k++) exp_ab_q.push_back(2'(k));
    done_cnt = 0;
    start = 1'b1;
    tick();                       // edge E0
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    for (int c = 0; c <= 4 * SD; c++) begin
      if (c > 0) tick();          // now just after edge E0+c
      if (c == poke_cyc) start = 1'b1;
      else start = 1'b0;
      if ((c % SD == 0) && (exp_ab_q.size() > 0)) begin
        exp_ab = exp_ab_q.pop_front();
        check({tag, "_ab"},   32'({a, b}), 32'(exp_ab));
        check({tag, "_step"}, 32'(step), 32'(exp_ab));
      end
      if (done) done_cnt++;
      if (c == 4 * SD - 1) check({tag, "_done_early"}, 32'(done), 32'd0);
    end
    start = 1'b0;
    check({tag, "_done"},    32'(done), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_err"},     32'(err_count), 32'(exp_err));
    check({tag, "_pass"},    32'(pass), 32'(exp_pass));
    check({tag, "_led_oe"},  32'(led_oe), 32'd1);
    check({tag, "_led_o"},   32'(led_o), 32'(exp_pass));
    tick();
    if (done) done_cnt++;
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_ab_hold"}, 32'({a, b}), 32'd3);
    check({tag, "_pass_hold"}, 32'(pass), 32'(exp_pass));
    check({tag, "_q_empty"}, 32'(exp_ab_q.size()), 32'd0);
  endtask

  initial begin
    int done_cnt;
    reset     = 1'b0;
    start     = 1'b0;
    start2    = 1'b0;
    gate_mode = 0;
    tick();
    tick();
    check_reset_vals("rst");

    // Reset and start together: reset wins.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_vs_start_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();
    check("rst_vs_start_idle", 32'(busy), 32'd0);

    run_single("healthy",  0, 0, -1);
    run_single("stuck0",   1, 1, -1);
    run_single("inverted", 2, 4, -1);
    run_single("poke",     0, 0, 6);

    // Abort mid-run: reset sampled at edge E0+9.
    gate_mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) tick();
    reset = 1'b0;
    tick();
    check_reset_vals("abort");
    reset = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);
    run_single("after_abort", 0, 0, -1);

    // LOOP=1 with stuck-at-1 gate: three errors per lap, saturating at 7.
    loop_q.push_back('{1,  3'd0});
    loop_q.push_back('{2,  3'd1});
    loop_q.push_back('{7,  3'd2});
    loop_q.push_back('{12, 3'd3});
    loop_q.push_back('{22, 3'd4});
    loop_q.push_back('{32, 3'd6});
    loop_q.push_back('{41, 3'd6});
    loop_q.push_back('{42, 3'd7});
    loop_q.push_back('{47, 3'd7});
    loop_q.push_back('{60, 3'd7});
    loop_q.push_back('{75, 3'd7});
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (done2) done_cnt++;
      if (c == 20) check("loop_wrap_step", 32'(step2), 32'd0);
      if ((loop_q.size() > 0) && (loop_q[0].cyc == c)) begin
        ev_t ev;
        ev = loop_q.pop_front();
        check($sformatf("loop_err_c%0d", c), 32'(err_count2), 32'(ev.err));
      end
    end
    check("loop_no_done", 32'(done_cnt), 32'd0);
    check("loop_busy",    32'(busy2), 32'd1);
    check("loop_pass",    32'(pass2), 32'd0);
    check("loop_led_oe",  32'(led_oe2), 32'd0);
    check("loop_q_empty", 32'(loop_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
